// File: rtl/dmem_pkg.sv
// Shared defaults, latency limits and response record for the data memory controller.
package dmem_pkg;
  localparam int              DEF_ADDR_W    = 32;
  localparam int              DEF_DATA_W    = 32;
  localparam int              DEF_DEPTH     = 1024;
  localparam int              DEF_RD_LAT    = 1;
  localparam logic [31:0]     DEF_BASE_ADDR = 32'h0;
  localparam int              RD_LAT_MIN    = 1;
  localparam int              RD_LAT_MAX    = 4;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

  // Index width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rsp_fifo.sv
// Circular response buffer; pointers wrap modulo DEPTH, head is visible combinationally.
module rsp_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);
  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) slots[wr_ptr_q] <= din_i;
  end

  assign dout_o  = slots[rd_ptr_q];
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with valid/ready request and response channels,
// fixed read latency and a response buffer that absorbs back-pressure.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter int                RD_LAT    = DEF_RD_LAT,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W/8-1:0] req_we_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(RD_LAT + 2);
  localparam int LAST  = RD_LAT - 1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("data_mem_ctrl: RD_LAT must lie in 1..4");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("data_mem_ctrl: DATA_W must be a multiple of 8");
  end

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_w_t;

  logic [ADDR_W-1:0] offset, word_idx;
  logic [IDX_W-1:0]  idx;
  logic              addr_err, is_write, accept, wr_en, rd_ok, deliver;

  always_comb begin
    offset   = req_addr_i - BASE_ADDR;
    word_idx = offset / ADDR_W'(NB);
    addr_err = (req_addr_i < BASE_ADDR) ||
               ((req_addr_i % ADDR_W'(NB)) != '0) ||
               (word_idx >= ADDR_W'(DEPTH));
    idx      = word_idx[IDX_W-1:0];
    is_write = |req_we_i;
    accept   = req_valid_i && req_ready_o;
    wr_en    = accept && !addr_err && is_write;
    rd_ok    = accept && !addr_err && !is_write;
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rdata_q;

  // Read samples the array before this edge's write, which only matters for
  // the accepting request itself; earlier writes are already visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_we_i[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
    if (accept) mem_rdata_q <= mem[idx];
  end

  logic [RD_LAT-1:0] pv_q, pv_d;
  logic              prd_q, prd_d, perr_q, perr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(accept) - CNT_W'(deliver);
    ready_d = (cnt_d < CNT_W'(RD_LAT + 1));
    pv_d[0] = accept;
    for (int i = 1; i < RD_LAT; i++) pv_d[i] = pv_q[i-1];
    prd_d   = accept ? rd_ok : prd_q;
    perr_d  = accept ? addr_err : perr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= '0;
      prd_q   <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      pv_q    <= pv_d;
      prd_q   <= prd_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  rsp_w_t stg0, pipe_rsp, fifo_head, head;

  always_comb begin
    stg0.rdata = prd_q ? mem_rdata_q : '0;
    stg0.err   = perr_q;
  end

  if (RD_LAT == 1) begin : g_lat1
    assign pipe_rsp = stg0;
  end else begin : g_shift
    rsp_w_t data_q [RD_LAT-1];
    rsp_w_t data_d [RD_LAT-1];
    always_comb begin
      data_d[0] = stg0;
      for (int i = 1; i < RD_LAT - 1; i++) data_d[i] = data_q[i-1];
    end
    always_ff @(posedge clk) data_q <= data_d;
    assign pipe_rsp = data_q[RD_LAT-2];
  end

  logic fifo_empty, push, pop;

  // The pipeline tail bypasses an empty buffer so latency is not padded by a cycle.
  always_comb begin
    push = pv_q[LAST] && !(fifo_empty && rsp_ready_i);
    pop  = !fifo_empty && rsp_ready_i;
  end

  rsp_fifo #(
    .DEPTH (RD_LAT + 1),
    .WIDTH (DATA_W + 1)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (pipe_rsp),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  always_comb begin
    head        = fifo_empty ? pipe_rsp : fifo_head;
    rsp_valid_o = pv_q[LAST] || !fifo_empty;
    rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    rsp_err_o   = rsp_valid_o && head.err;
    deliver     = rsp_valid_o && rsp_ready_i;
    req_ready_o = ready_q;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl at RD_LAT=3, DEPTH=1024.
module tb_data_mem_ctrl;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [3:0]  req_we_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          acc_cyc [$];
  int          rsp_cyc [$];
  logic [31:0] rsp_dat [$];
  logic        rsp_er  [$];

  data_mem_ctrl #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DEPTH     (1024),
    .RD_LAT    (LAT),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the negedge view is what the next edge consumes.
  always @(negedge clk) begin
    if (rst_n && req_valid_i && req_ready_o) acc_cyc.push_back(cyc);
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(rsp_rdata_o);
      rsp_er.push_back(rsp_err_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    acc_cyc.delete(); rsp_cyc.delete(); rsp_dat.delete(); rsp_er.delete();
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    bit ok = 0;
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_wdata_i = wd;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready_o;
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0; req_we_i = '0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: addr %h never accepted", addr);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 400 && rsp_dat.size() < n; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if (rsp_dat.size() < n) begin
      bad++;
      $display("FAIL rsp_timeout: got %0d responses want %0d", rsp_dat.size(), n);
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid_o); end
    total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", rsp_err_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", req_ready_o); end
    @(posedge clk); #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", req_ready_o); end
  endtask

  task automatic test_write_read();
    clear_q();
    issue(32'h100, 4'hF, 32'hDEADBEEF);
    issue(32'h100, 4'h0, 32'h0);
    wait_rsp(2);
    if (rsp_dat.size() >= 2 && acc_cyc.size() >= 2) begin
      total++; if (rsp_dat[0] !== 32'h0 || rsp_er[0] !== 1'b0) begin bad++; $display("FAIL wr_rsp: got %h/%b want 0/0", rsp_dat[0], rsp_er[0]); end
      total++; if (rsp_dat[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_data: got %h want deadbeef", rsp_dat[1]); end
      total++; if (rsp_er[1] !== 1'b0) begin bad++; $display("FAIL raw_err: got %b want 0", rsp_er[1]); end
      total++; if (acc_cyc[1] - acc_cyc[0] !== 1) begin bad++; $display("FAIL raw_b2b: gap %0d want 1", acc_cyc[1] - acc_cyc[0]); end
      total++; if (rsp_cyc[1] - acc_cyc[1] !== LAT) begin bad++; $display("FAIL rd_latency: got %0d want %0d", rsp_cyc[1] - acc_cyc[1], LAT); end
    end
  endtask

  task automatic test_byte_lanes();
    clear_q();
    issue(32'h104, 4'hF,    32'h11223344);
    issue(32'h104, 4'b0001, 32'h000000AA);
    issue(32'h104, 4'h0,    32'h0);
    issue(32'h104, 4'b0100, 32'h00550000);
    issue(32'h104, 4'h0,    32'h0);
    wait_rsp(5);
    if (rsp_dat.size() >= 5) begin
      total++; if (rsp_dat[2] !== 32'h112233AA) begin bad++; $display("FAIL lane0: got %h want 112233aa", rsp_dat[2]); end
      total++; if (rsp_dat[4] !== 32'h115533AA) begin bad++; $display("FAIL lane2: got %h want 115533aa", rsp_dat[4]); end
      total++; if (rsp_er[2] !== 1'b0 || rsp_er[4] !== 1'b0) begin bad++; $display("FAIL lane_err: got %b%b want 00", rsp_er[2], rsp_er[4]); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] a [9];
    logic [3:0]  w [9];
    logic [31:0] d [9];
    logic [31:0] ed [9];
    logic        ee [9];
    a  = '{32'h000, 32'h1000, 32'h102, 32'h102, 32'h1000, 32'h000, 32'h100, 32'hFFC, 32'hFFC};
    w  = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
    d  = '{32'h0BADF00D, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE0001, 32'h0};
    ed = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 32'hDEADBEEF, 32'h0, 32'hCAFE0001};
    ee = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    clear_q();
    for (int i = 0; i < 9; i++) issue(a[i], w[i], d[i]);
    wait_rsp(9);
    for (int i = 0; i < 9 && i < rsp_dat.size(); i++) begin
      total++;
      if (rsp_dat[i] !== ed[i] || rsp_er[i] !== ee[i]) begin
        bad++;
        $display("FAIL err_vec%0d: got %h/%b want %h/%b", i, rsp_dat[i], rsp_er[i], ed[i], ee[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] ed [6];
    logic        ee [6];
    ed = '{32'hDEADBEEF, 32'h115533AA, 32'h0BADF00D, 32'hCAFE0001, 32'h0, 32'h0BADF00D};
    ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clear_q();
    rsp_ready_i = 1'b0;
    issue(32'h100, 4'h0, 32'h0);
    issue(32'h104, 4'h0, 32'h0);
    issue(32'h000, 4'h0, 32'h0);
    issue(32'hFFC, 4'h0, 32'h0);
    req_valid_i = 1'b1; req_addr_i = 32'h102; req_we_i = 4'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready%0d: got %b want 0", k, req_ready_o); end
      total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEEF) begin
        bad++; $display("FAIL hold%0d: got %b/%h want 1/deadbeef", k, rsp_valid_o, rsp_rdata_o);
      end
      @(posedge clk); #1;
    end
    total++; if (acc_cyc.size() !== 4) begin bad++; $display("FAIL stall_accepts: got %0d want 4", acc_cyc.size()); end
    rsp_ready_i = 1'b1;
    issue(32'h102, 4'h0, 32'h0);
    issue(32'h000, 4'h0, 32'h0);
    wait_rsp(6);
    total++; if (acc_cyc.size() !== 6) begin bad++; $display("FAIL resume_accepts: got %0d want 6", acc_cyc.size()); end
    for (int i = 0; i < 6 && i < rsp_dat.size(); i++) begin
      total++;
      if (rsp_dat[i] !== ed[i] || rsp_er[i] !== ee[i]) begin
        bad++;
        $display("FAIL bp_order%0d: got %h/%b want %h/%b", i, rsp_dat[i], rsp_er[i], ed[i], ee[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] sa [4];
    logic [31:0] sd [4];
    sa = '{32'h000, 32'h100, 32'h104, 32'hFFC};
    sd = '{32'h0BADF00D, 32'hDEADBEEF, 32'h115533AA, 32'hCAFE0001};
    clear_q();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 4'h0;
    for (int i = 0; i < 100; i++) begin
      req_addr_i = sa[i % 4];
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    wait_rsp(100);
    total++; if (acc_cyc.size() !== 100) begin bad++; $display("FAIL stream_accepts: got %0d want 100", acc_cyc.size()); end
    if (acc_cyc.size() == 100) begin
      total++; if (acc_cyc[99] - acc_cyc[0] !== 99) begin bad++; $display("FAIL stream_span: got %0d want 99", acc_cyc[99] - acc_cyc[0]); end
    end
    for (int i = 0; i < 100 && i < rsp_dat.size(); i++) begin
      total++;
      if (rsp_dat[i] !== sd[i % 4] || rsp_er[i] !== 1'b0) begin
        bad++;
        $display("FAIL stream%0d: got %h/%b want %h/0", i, rsp_dat[i], rsp_er[i], sd[i % 4]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_q();
    issue(32'h200, 4'hF, 32'h5A5A1234);
    rsp_ready_i = 1'b0;
    issue(32'h200, 4'h0, 32'h0);
    issue(32'h000, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL pre_rst_valid: got %b want 1", rsp_valid_o); end
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got %b want 0", rsp_valid_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL async_rst_ready: got %b want 0", req_ready_o); end
    total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL async_rst_rdata: got %h want 0", rsp_rdata_o); end
    clear_q();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; end
    total++; if (rsp_dat.size() !== 0) begin bad++; $display("FAIL stale_rsp: got %0d want 0", rsp_dat.size()); end
    issue(32'h200, 4'h0, 32'h0);
    wait_rsp(1);
    if (rsp_dat.size() >= 1) begin
      total++; if (rsp_dat[0] !== 32'h5A5A1234 || rsp_er[0] !== 1'b0) begin
        bad++; $display("FAIL persist: got %h/%b want 5a5a1234/0", rsp_dat[0], rsp_er[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_back_pressure();
    test_stream();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
